// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a program image as a byte stream (valid/ready), packs
//            the bytes into 32-bit little-endian words and writes them into
//            instruction memory from word 0. The core is held in reset until
//            a complete, well-formed image has been written.
//            Image: LEN[7:0], LEN[15:8], then LEN words (LSB first).
// Option   : BOOT_CHECKSUM_EN adds a trailing mod-256 checksum byte over all
//            data bytes, checked in state CHK.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start             - load request (honoured in IDLE/DONE/ERROR)
//            in_valid/in_data  - byte stream input
//            in_ready          - byte accepted when in_valid && in_ready
//            imem_we/addr/wdata- one-cycle word write strobe, address, data
//            core_n_rst        - active-low core reset, high only in DONE
//            busy/done/error   - load status
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_n_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_C = 17'(IMEM_DEPTH);

  state_t      state;
  state_t      nxt;
  state_t      s_final;     // where the image ends up after its last word
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;    // lower three lanes; the fourth comes straight from in_data
  logic        accept;
  logic [15:0] len_in;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept = in_valid && in_ready;
  assign len_in = {in_data, len[7:0]};

`ifdef BOOT_CHECKSUM_EN
  assign s_final = S_CHK;
`else
  assign s_final = S_DONE;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_LEN_LO;
      S_LEN_LO: if (accept) nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_in} > DEPTH_C) nxt = S_ERROR;
          else if (len_in == 16'd0)     nxt = s_final;
          else                          nxt = S_DATA;
        end
      end
      S_DATA: begin
        // Leave DATA on the edge that accepts the last byte of the last word,
        // so no stray byte can be consumed during the final write cycle.
        if (accept && byte_idx == 2'd3 && word_cnt == len - 16'd1) nxt = s_final;
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK:    if (accept) nxt = (in_data == csum) ? S_DONE : S_ERROR;
`endif
      S_DONE:   if (start) nxt = S_LEN_LO;
      S_ERROR:  if (start) nxt = S_LEN_LO;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_n_rst <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      len        <= 16'd0;
      word_cnt   <= 16'd0;
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= (nxt == S_LEN_LO) || (nxt == S_LEN_HI) ||
                  (nxt == S_DATA)   || (nxt == S_CHK);
      busy     <= (nxt == S_LEN_LO) || (nxt == S_LEN_HI) ||
                  (nxt == S_DATA)   || (nxt == S_CHK);
      done     <= (nxt == S_DONE);
      error    <= (nxt == S_ERROR);
      // Rises one edge after DONE is entered; falls on the restart edge.
      core_n_rst <= (state == S_DONE) && (nxt == S_DONE);
      imem_we    <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            len      <= 16'd0;
            word_cnt <= 16'd0;
            byte_idx <= 2'd0;
            word_buf <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        S_LEN_LO: if (accept) len[7:0]  <= in_data;
        S_LEN_HI: if (accept) len[15:8] <= in_data;
        S_DATA: begin
          if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            csum <= csum + in_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {in_data, word_buf};
              word_cnt   <= word_cnt + 16'd1;
            end else begin
              word_buf[8*byte_idx +: 8] <= in_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader. Images are built from
//            random or fixed bytes; expected writes and outcome come from the
//            image format rules (LEN words, little-endian, optional checksum).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, core_n_rst, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_n_rst(core_n_rst), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            bad_rdy = 0;
  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_data[$];
  logic [7:0]    img[$];

  // Write capture and ready-while-busy monitor.
  always @(negedge clk) begin
    if (imem_we) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
    end
    if (busy && !in_ready) bad_rdy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one byte after 'gap' idle cycles; returns at the negedge after the
  // accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  // Full load of 'len' words taken from img, with idle gaps in [glo,ghi].
  task automatic run_load(input int len, input int glo, input int ghi,
                          input bit bad_sum, input bit poke_start);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [15:0] l16;
    bit          exp_err;
    l16 = 16'(len);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_nrst", 32'(core_n_rst), 32'd0);
    send_byte(l16[7:0], int'($urandom_range(ghi, glo)));
    send_byte(l16[15:8], int'($urandom_range(ghi, glo)));
    if (len > DEPTH) begin
      check("len_err", 32'(error), 32'd1);
      check("len_err_rdy", 32'(in_ready), 32'd0);
      repeat (4) @(negedge clk);
      check("len_err_nowr", 32'(cap_addr.size()), 32'd0);
      check("len_err_nrst", 32'(core_n_rst), 32'd0);
      return;
    end
    sum = 8'd0;
    for (int i = 0; i < 4 * len; i++) begin
      if (poke_start && i == 3) pulse_start();
      send_byte(img[i], int'($urandom_range(ghi, glo)));
      sum = sum + img[i];
    end
    exp_err = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    check("chk_wait", 32'(busy), 32'd1);
    send_byte(bad_sum ? sum + 8'd1 : sum, int'($urandom_range(ghi, glo)));
    exp_err = bad_sum;
`endif
    check("fin_done", 32'(done), 32'(!exp_err));
    check("fin_err", 32'(error), 32'(exp_err));
    check("fin_nrst_lag", 32'(core_n_rst), 32'd0);
    @(negedge clk);
    check("fin_nrst", 32'(core_n_rst), 32'(!exp_err));
    @(negedge clk);
    check("wr_count", 32'(cap_addr.size()), 32'(len));
    for (int i = 0; i < len && i < cap_addr.size(); i++) begin
      w = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      check($sformatf("wr_addr[%0d]", i), 32'(cap_addr[i]), 32'(i));
      check($sformatf("wr_data[%0d]", i), cap_data[i], w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    @(negedge clk);
    do_reset();

    // Reset / idle behaviour
    repeat (5) @(negedge clk);
    check("rst_nrst", 32'(core_n_rst), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_nowr", 32'(cap_addr.size()), 32'd0);

    // Normal two-word load
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    run_load(2, 0, 0, 1'b0, 1'b0);
    check("norm_w0", cap_data[0], 32'h00A00513);
    check("norm_w1", cap_data[1], 32'h00500593);

    // Same image with 3-cycle gaps and a start pulse ignored mid-load
    bad_rdy = 0;
    run_load(2, 3, 3, 1'b0, 1'b1);
    check("gap_w0", cap_data[0], 32'h00A00513);
    check("gap_w1", cap_data[1], 32'h00500593);
    check("gap_ready", 32'(bad_rdy), 32'd0);

    // Oversize length, then zero length
    run_load(1025, 0, 1, 1'b0, 1'b0);
    run_load(0, 0, 1, 1'b0, 1'b0);

    // Abort after 6 data bytes of a 4-word image, then full reload
    fill_random(16);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(img[i], int'($urandom_range(1, 0)));
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_wr", 32'(cap_addr.size()), 32'd1);
    check("abort_addr", 32'(cap_addr[0]), 32'd0);
    check("abort_data", cap_data[0], {img[3], img[2], img[1], img[0]});
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_nrst", 32'(core_n_rst), 32'd0);
    run_load(4, 0, 2, 1'b0, 1'b0);

    // One-word image 01 02 03 04 (checksum 0x0A when enabled)
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 0, 1'b0, 1'b0);
    check("one_w0", cap_data[0], 32'h04030201);
`ifdef BOOT_CHECKSUM_EN
    run_load(1, 0, 0, 1'b1, 1'b0);
`endif

    // Length equal to memory depth
    fill_random(4 * DEPTH);
    run_load(DEPTH, 0, 0, 1'b0, 1'b0);
    check("full_last_addr", 32'(cap_addr[DEPTH-1]), 32'(DEPTH - 1));

    // Randomized loads
    for (int n = 0; n < 6; n++) begin
      int len;
      len = int'($urandom_range(6, 0));
      fill_random(4 * len);
      run_load(len, 0, 3, ($urandom_range(3, 0) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-path block that sits directly upstream of the RV32I core top. It receives a program as a byte stream using a valid/ready handshake. It packs the bytes into 32-bit little-endian words and writes them sequentially into instruction memory from word address 0. The core is held in reset until a complete, well-formed image has been written. This replaces backdoor memory preloading, so programs can be loaded through real RTL.

Parameters:
IMEM_DEPTH, 1024, number of 32-bit words in instruction memory.
ADDR_W, $clog2(IMEM_DEPTH), width of the word address.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE/ERROR
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  word to write
core_n_rst  output  1  active-low reset to the core; high only in DONE
busy  output  1  high in LEN_LO, LEN_HI, DATA, CHK
done  output  1  high while in DONE
error  output  1  high while in ERROR

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - Outputs: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_n_rst=0, busy=0, done=0, error=0.
  - Byte counter, word counter and length register are cleared.
- Byte transfer: a byte is accepted only on a cycle with in_valid && in_ready.
- in_ready is registered-state decoded: 1 in LEN_LO, LEN_HI, DATA, CHK; 0 otherwise.
- Image format: LEN[7:0], then LEN[15:8], then LEN words of 4 bytes each, least-significant byte first.
- States and transitions:
  - IDLE: start -> LEN_LO.
  - LEN_LO: accept byte -> LEN_HI.
  - LEN_HI: accept byte, then choose:
    - if LEN > IMEM_DEPTH -> ERROR;
    - else if LEN == 0 -> DONE (or CHK when CHECKSUM_EN is defined);
    - else -> DATA.
  - DATA:
    - A 2-bit byte index selects which lane of the word buffer the byte goes into.
    - When the 4th byte of a word is accepted, on the next edge: imem_we=1 for exactly one cycle, with imem_addr=word counter and imem_wdata=the assembled word.
    - The word counter then increments.
    - After word LEN-1 is written -> DONE (or CHK).
    - Write latency is 1 cycle from acceptance of the last byte to imem_we.
    - in_ready stays 1 during the write cycle; no back-pressure is needed.
  - DONE: core_n_rst=1 (registered, so the core leaves reset on the first edge after DONE is entered). start -> LEN_LO, and core_n_rst drops to 0 on that same edge.
  - ERROR: core_n_rst=0, error=1; only start or rst leave this state. start -> LEN_LO.
- Gaps in in_valid are allowed in any receiving state; the state, counters and partial word are held across the gap.
- start while busy is ignored.
- rst mid-load aborts immediately:
  - no further imem_we;
  - words already written are left in memory;
  - core stays in reset.
- imem_addr wraps at width ADDR_W. Wrap never occurs in a legal load, because LEN ≤ IMEM_DEPTH.
- LEN == IMEM_DEPTH is legal and fills memory exactly.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (modulo 256) of every data byte is kept.
  - Length bytes are excluded from the sum; the sum is cleared on start.
  - After the last word, state CHK accepts one byte.
  - Byte == sum -> DONE; byte != sum -> ERROR.
  - For LEN == 0 the expected checksum byte is 0x00.
- Undefined: CHK is absent; the last word (or LEN == 0) goes straight to DONE, and no trailing byte is consumed.

Test Plan:
- Reset behaviour: rst high for 2 cycles, then low with no start -> core_n_rst=0, in_ready=0, imem_we never asserts, state stays IDLE.
- Normal load: start, then bytes 02 00 13 05 A0 00 93 05 50 00 -> exactly two imem_we pulses:
  - addr 0, data 00A00513;
  - addr 1, data 00500593;
  - then done=1 and core_n_rst=1 on the following edge.
- Back-pressure gaps: same image as above with in_valid low for 3 cycles between every byte -> identical writes and identical final state; in_ready=1 throughout busy.
- Error and zero length:
  - LEN bytes 01 04 (1025 > IMEM_DEPTH) -> error=1, no imem_we, core_n_rst=0;
  - then start with LEN 00 00 -> done=1 with no writes.
- Abort and reload: rst after 6 data bytes of a 4-word image -> exactly one write (addr 0); idle afterwards. Then start and a full reload -> 4 writes at addr 0..3 and done=1.
- BOOT_CHECKSUM_EN, image 01 00 01 02 03 04:
  - trailing byte 0A -> DONE;
  - trailing byte 0B -> ERROR, core_n_rst=0;
  - without the macro defined, the same image without a trailer -> DONE immediately after the word is written.
